lut_mult_scheduler: RTL and testbench
=====================================

Name: lut_mult_scheduler

Overview:
- Time-shares one constant-coefficient 8-bit LUT multiplier (8-bit X in, 16-bit C out) among N_REQ requesters.
- Provides round-robin arbitration, operand capture and multiplier issue.
- Waits out the multiplier latency, then returns a tagged 16-bit product over a valid/ready response channel with backpressure.
- Sits between requesting datapath units and the single shared multiplier instance at the same hierarchy level.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the response tag. Must satisfy 2**ID_W >= N_REQ.
- MUL_LAT, 0: multiplier pipeline depth in cycles, 0..7. 0 means a combinational multiplier.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- req_valid  in  N_REQ  Per-requester request valid.
- req_data  in  8*N_REQ  Per-requester operand. Requester i uses bits [8i+7:8i].
- req_ready  out  N_REQ  Per-requester accept. One-hot or zero.
- mul_x  out  8  Operand driven to the shared multiplier.
- mul_c  in  16  Product returned by the shared multiplier.
- rsp_valid  out  1  Response valid.
- rsp_ready  in  1  Response accept from the consumer.
- rsp_data  out  16  Product.
- rsp_id  out  ID_W  Index of the requester that owns rsp_data.

Behaviour:
- Reset values (on rst at a clock edge):
  - state=IDLE, ptr=0, wait counter=0.
  - mul_x=0, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Any in-flight operation is dropped with no response.
- States: IDLE, WAIT, RESP.
- IDLE:
  - grant = first index i with req_valid[i]=1, searching cyclically from ptr.
  - req_ready[grant]=1 combinationally. All other req_ready bits are 0.
  - req_ready is all-zero if no request is valid, outside IDLE, or while rst=1.
  - On accept:
    - x_reg <= req_data[grant]; id_reg <= grant.
    - ptr <= (grant+1) mod N_REQ.
    - cnt <= MUL_LAT; go to WAIT.
- WAIT:
  - mul_x = x_reg, held stable.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture rsp_data <= mul_c and rsp_id <= id_reg, then go to RESP.
  - WAIT therefore lasts exactly MUL_LAT+1 cycles.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready=1.
  - On handshake, go to IDLE. rsp_valid drops the next cycle.
- Latency: accept in cycle t gives rsp_valid first high in cycle t+MUL_LAT+2.
  - With rsp_ready tied high, the minimum issue spacing is MUL_LAT+3 cycles.
- Requester rule:
  - Once req_valid is raised it stays high, with stable data, until req_ready.
  - The scheduler tolerates violations: it samples only in the accept cycle.
- Boundary conditions:
  - ptr wraps from N_REQ-1 to 0.
  - A single persistent requester is granted every IDLE visit.
  - All requesters valid: grants follow ptr order 0,1,2,3,0,...
  - rsp_ready held low: stays in RESP indefinitely and accepts no new request.
  - rsp_ready high before RESP: ignored.
  - mul_x holds its last operand in IDLE and RESP.
  - rst asserted in any state returns to the reset values on that edge.

Optional Feature:
- Macro: LUT_SCHED_STATS_EN.
- Defined:
  - Adds output stat_grants, width 16*N_REQ: per-requester saturating grant counters.
  - Adds output stat_stall, width 16: saturating count of cycles in RESP with rsp_ready=0.
  - All counters clear on rst.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package lut_mult_pkg:
  - state enum (IDLE, WAIT, RESP).
  - Constants OP_W=8, PROD_W=16, STAT_W=16.
- Sub-module lut_rr_arbiter, parameterised by N_REQ:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the scheduler owns the ptr register.
- Scheduler top: FSM, operand/tag registers, wait counter and stats.

Test Plan:
- Reset check: rst high for 3 cycles, all req_valid=1. Expect req_ready=0, rsp_valid=0 and mul_x=0 throughout; first grant after release is requester 0.
- Single request, MUL_LAT=0, bench model mul_c=mul_x*2: requester 2 sends 0x7F at cycle t. Expect rsp_valid at t+2 with rsp_data=0x00FE and rsp_id=2.
- Round-robin fairness: all 4 valid continuously with operands 0x01,0x02,0x03,0x04. Expect rsp_id sequence 0,1,2,3,0 and rsp_data 0x0002,0x0004,0x0006,0x0008.
- Backpressure, MUL_LAT=3, A=5 model: accept 0xFF and hold rsp_ready=0 for 10 cycles. Expect rsp_data=0x04FB held stable and no req_ready asserted; stat_stall=10 when LUT_SCHED_STATS_EN is defined.
- Reset mid-operation: assert rst during WAIT. Expect no response, state IDLE and ptr=0; the next request from requester 1 completes normally.
- Pointer wrap: only requester 3 is valid, then requesters 0 and 3. Expect grant 3, then 0 (ptr wrapped to 0), then 3.

Source files
------------

// File: rtl/lut_mult_pkg.sv
// Purpose: shared types and widths for the LUT multiplier scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scheduler state encoding, operand/product/statistics widths.
package lut_mult_pkg;

  localparam int OP_W   = 8;   // multiplier operand width
  localparam int PROD_W = 16;  // multiplier product width
  localparam int STAT_W = 16;  // width of each saturating statistics counter

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // arbitrating, waiting for a request
    WAIT = 2'd1,  // operand on the multiplier, waiting out its latency
    RESP = 2'd2   // product held on the response channel
  } state_t;

endpackage

// File: rtl/lut_rr_arbiter.sv
// Purpose: combinational round-robin pick among N_REQ requesters, searching from ptr.
// Latency: 0 cycles (purely combinational).
// Backpressure: none of its own; en=0 forces an all-zero grant.
//
// Ports:
//   req        request vector, bit i = requester i
//   ptr        index the cyclic search starts from (owned by the caller)
//   en         allows a grant this cycle
//   grant      one-hot grant, or zero when nothing is granted
//   grant_idx  encoded index of the granted requester
//   grant_vld  a grant is being issued
module lut_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        // ptr is always < N_REQ, so one conditional subtraction wraps the index
        j = int'(ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        if (!grant_vld && req[j]) begin
          grant_vld = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/lut_mult_scheduler.sv
// Purpose: time-shares one constant-coefficient LUT multiplier among N_REQ requesters.
// Latency: accept in cycle t -> rsp_valid first high in cycle t+MUL_LAT+2.
// Backpressure: rsp_ready low holds the response and blocks all new accepts.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid/req_data/req_ready  per-requester request channel (8-bit operand each)
//   mul_x / mul_c             operand to / product from the shared multiplier
//   rsp_valid/rsp_ready/rsp_data/rsp_id  tagged product response channel
// Optional build macro LUT_SCHED_STATS_EN adds:
//   stat_grants               per-requester saturating grant counters (16 bits each)
//   stat_stall                saturating count of RESP cycles with rsp_ready low
module lut_mult_scheduler
  import lut_mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [OP_W-1:0]         mul_x,
  input  logic [PROD_W-1:0]       mul_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PROD_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id
`ifdef LUT_SCHED_STATS_EN
  ,
  output logic [STAT_W*N_REQ-1:0] stat_grants,
  output logic [STAT_W-1:0]       stat_stall
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 3;  // holds MUL_LAT up to 7

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OP_W-1:0]   x_reg;
  logic [ID_W-1:0]   id_reg;

  logic              arb_en;
  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [OP_W-1:0]   grant_op;
  logic              capture;

  // Arbitration only in IDLE; gating with rst keeps req_ready low during reset.
  assign arb_en = (state == IDLE) && !rst;

  lut_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // One-hot grant selects the operand with an AND-OR mux.
  always_comb begin
    grant_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_op = grant_op | req_data[i*OP_W +: OP_W];
    end
  end

  assign req_ready = grant;
  assign mul_x     = x_reg;   // stays on the last operand outside WAIT
  assign rsp_valid = (state == RESP);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(MUL_LAT);
          ptr_nxt   = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      WAIT: begin
        // cnt reaches zero on the cycle the multiplier output is valid
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      x_reg    <= '0;
      id_reg   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      if (grant_vld) begin
        x_reg  <= grant_op;
        id_reg <= ID_W'(grant_idx);
      end
      if (capture) begin
        rsp_data <= mul_c;
        rsp_id   <= id_reg;
      end
    end
  end

`ifdef LUT_SCHED_STATS_EN
  logic [STAT_W-1:0] grant_cnt [N_REQ];
  logic [STAT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if ((state == RESP) && !rsp_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
    assign stat_grants[gi*STAT_W +: STAT_W] = grant_cnt[gi];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_lut_mult_scheduler.sv
// Purpose: self-checking bench for lut_mult_scheduler, one instance with a
//          combinational x*2 multiplier and one with a 3-stage x*5 multiplier.
// Latency/backpressure: exercised through directed phases and random traffic.
module tb_lut_mult_scheduler;

  localparam int N     = 4;
  localparam int LAT0  = 0;
  localparam int LAT1  = 3;
  localparam int COEF0 = 2;
  localparam int COEF1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid [2];
  logic [8*N-1:0] req_data  [2];
  logic [N-1:0]   req_ready [2];
  logic [7:0]     mul_x     [2];
  logic [15:0]    mul_c     [2];
  logic           rsp_valid [2];
  logic           rsp_ready [2];
  logic [15:0]    rsp_data  [2];
  logic [1:0]     rsp_id    [2];
`ifdef LUT_SCHED_STATS_EN
  logic [16*N-1:0] stat_grants [2];
  logic [15:0]     stat_stall  [2];
`endif

  // Multiplier models: combinational x*2, and a 3-deep pipeline of x*5.
  logic [15:0] pipe [3];
  assign mul_c[0] = 16'(mul_x[0]) * 16'(COEF0);
  always @(posedge clk) begin
    pipe[0] <= 16'(mul_x[1]) * 16'(COEF1);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mul_c[1] = pipe[2];

  lut_mult_scheduler #(.N_REQ(N), .ID_W(2), .MUL_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
    .mul_x(mul_x[0]), .mul_c(mul_c[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0])
`ifdef LUT_SCHED_STATS_EN
    , .stat_grants(stat_grants[0]), .stat_stall(stat_stall[0])
`endif
  );

  lut_mult_scheduler #(.N_REQ(N), .ID_W(2), .MUL_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
    .mul_x(mul_x[1]), .mul_c(mul_c[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1])
`ifdef LUT_SCHED_STATS_EN
    , .stat_grants(stat_grants[1]), .stat_stall(stat_stall[1])
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int coef_of(input int d);
    return (d == 0) ? COEF0 : COEF1;
  endfunction

  // First valid requester found walking cyclically from p, or -1.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level reference: one outstanding job with a due cycle.
  bit         m_busy [2] = '{1'b0, 1'b0};
  int         m_ptr  [2] = '{0, 0};
  int         m_due  [2] = '{0, 0};
  int         m_id   [2] = '{0, 0};
  logic [7:0] m_x    [2] = '{8'h00, 8'h00};
  logic [7:0] m_mx   [2] = '{8'h00, 8'h00};
  int         cyc = 0;

  // Logs of observed DUT handshakes for the directed literal checks.
  int          gl_n   [2] = '{0, 0};
  int          gl_idx [2][256];
  int          gl_cyc [2][256];
  int          rl_n   [2] = '{0, 0};
  logic [15:0] rl_data[2][256];
  int          rl_id  [2][256];
  int          rl_cyc [2][256];

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic exp_v;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      g       = rr_pick(req_valid[d], m_ptr[d]);
      exp_rdy = '0;
      if (!rst && !m_busy[d] && g >= 0) exp_rdy[g] = 1'b1;
      exp_v = m_busy[d] && (cyc >= m_due[d]);
      check("req_ready", d, 32'(req_ready[d]), 32'(exp_rdy));
      check("rsp_valid", d, 32'(rsp_valid[d]), 32'(exp_v));
      check("mul_x", d, 32'(mul_x[d]), 32'(m_mx[d]));
      if (exp_v) begin
        check("rsp_data", d, 32'(rsp_data[d]), int'(m_x[d]) * coef_of(d));
        check("rsp_id", d, 32'(rsp_id[d]), m_id[d]);
      end

      for (int i = 0; i < N; i++) begin
        if (req_valid[d][i] && req_ready[d][i] && gl_n[d] < 256) begin
          gl_idx[d][gl_n[d]] = i;
          gl_cyc[d][gl_n[d]] = cyc;
          gl_n[d]++;
        end
      end
      if (rsp_valid[d] && rsp_ready[d] && rl_n[d] < 256) begin
        rl_data[d][rl_n[d]] = rsp_data[d];
        rl_id[d][rl_n[d]]   = int'(rsp_id[d]);
        rl_cyc[d][rl_n[d]]  = cyc;
        rl_n[d]++;
      end

      // Advance the reference to what the coming edge produces.
      if (rst) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = 0;
        m_mx[d]   = 8'h00;
      end else if (!m_busy[d]) begin
        if (g >= 0) begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + lat_of(d) + 2;
          m_x[d]    = req_data[d][g*8 +: 8];
          m_id[d]   = g;
          m_ptr[d]  = (g + 1) % N;
          m_mx[d]   = req_data[d][g*8 +: 8];
        end
      end else if (cyc >= m_due[d] && rsp_ready[d]) begin
        m_busy[d] = 1'b0;
      end
    end
  end

  bit auto_drop = 1'b1;

  // One clock; requesters drop valid after an accept when auto_drop is set.
  task automatic tick();
    logic [N-1:0] acc [2];
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) acc[d] = req_valid[d] & req_ready[d];
    @(posedge clk);
    #1;
    if (auto_drop) begin
      for (int d = 0; d < 2; d++) req_valid[d] = req_valid[d] & ~acc[d];
    end
  endtask

  task automatic wait_cnt(input int d, input bit rsp, input int target, input int budget);
    int b;
    b = budget;
    while (((rsp ? rl_n[d] : gl_n[d]) < target) && b > 0) begin
      tick();
      b--;
    end
    check(rsp ? "wait_rsp" : "wait_grant", d, 32'((rsp ? rl_n[d] : gl_n[d]) >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int b;
    b = 60;
    while ((m_busy[0] || m_busy[1]) && b > 0) begin
      tick();
      b--;
    end
    check("wait_idle", 0, 32'(m_busy[0] || m_busy[1]), 32'd0);
  endtask

  initial begin
    int gb, rb, b;
    logic [15:0] exp16;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_data[d]  = '0;
      rsp_ready[d] = 1'b1;
    end

    // Reset with every requester valid; then round-robin over operands 1..4.
    auto_drop = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 4'b1111;
      req_data[d]  = 32'h04030201;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        check("rst_req_ready", d, 32'(req_ready[d]), 32'd0);
        check("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        check("rst_mul_x", d, 32'(mul_x[d]), 32'd0);
`ifdef LUT_SCHED_STATS_EN
        check("rst_stat_grants", d, 32'(stat_grants[d] != '0), 32'd0);
        check("rst_stat_stall", d, 32'(stat_stall[d]), 32'd0);
`endif
      end
    end
    rst = 1'b0;
    wait_cnt(0, 1'b1, 5, 100);
    wait_cnt(1, 1'b1, 5, 100);
    for (int d = 0; d < 2; d++) begin
      check("first_grant", d, gl_idx[d][0], 32'd0);
      check("rr_latency", d, rl_cyc[d][0] - gl_cyc[d][0], lat_of(d) + 2);
      for (int k = 0; k < 5; k++) begin
        check("rr_id", d, rl_id[d][k], k % 4);
        check("rr_data", d, 32'(rl_data[d][k]), ((k % 4) + 1) * coef_of(d));
      end
      req_valid[d] = '0;
    end
    wait_idle();

    // Single request from requester 2 with operand 0x7F.
    auto_drop = 1'b1;
    for (int d = 0; d < 2; d++) begin
      gb = gl_n[d];
      rb = rl_n[d];
      req_data[d][23:16] = 8'h7F;
      req_valid[d] = 4'b0100;
      wait_cnt(d, 1'b1, rb + 1, 40);
      exp16 = (d == 0) ? 16'h00FE : 16'h027B;
      check("single_data", d, 32'(rl_data[d][rb]), 32'(exp16));
      check("single_id", d, rl_id[d][rb], 32'd2);
      check("single_latency", d, rl_cyc[d][rb] - gl_cyc[d][gb], (d == 0) ? 2 : 5);
      wait_idle();
    end

    // Backpressure: operand 0xFF held for 10 cycles with rsp_ready low.
    for (int d = 0; d < 2; d++) begin
      rb = rl_n[d];
      rsp_ready[d] = 1'b0;
      req_data[d][7:0] = 8'hFF;
      req_valid[d] = 4'b0001;
      b = 20;
      while (!rsp_valid[d] && b > 0) begin
        tick();
        b--;
      end
      check("bp_rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
      req_data[d][15:8] = 8'h11;
      req_valid[d][1] = 1'b1;
      exp16 = (d == 0) ? 16'h01FE : 16'h04FB;
      for (int c = 0; c < 10; c++) begin
        tick();
        check("bp_data", d, 32'(rsp_data[d]), 32'(exp16));
        check("bp_held_valid", d, 32'(rsp_valid[d]), 32'd1);
        check("bp_req_ready", d, 32'(req_ready[d]), 32'd0);
      end
`ifdef LUT_SCHED_STATS_EN
      check("stat_stall", d, 32'(stat_stall[d]), 32'd10);
`endif
      rsp_ready[d] = 1'b1;
      wait_cnt(d, 1'b1, rb + 2, 40);
      check("bp_next_id", d, rl_id[d][rb + 1], 32'd1);
      check("bp_next_data", d, 32'(rl_data[d][rb + 1]), 32'h11 * coef_of(d));
      wait_idle();
    end

    // Reset during WAIT: no response, pointer back to 0.
    for (int d = 0; d < 2; d++) begin
      gb = gl_n[d];
      rb = rl_n[d];
      req_data[d][23:16] = 8'h33;
      req_valid[d] = 4'b0100;
      wait_cnt(d, 1'b0, gb + 1, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      check("no_rsp_after_rst", d, rl_n[d], rb);
      gb = gl_n[d];
      req_data[d][15:8]  = 8'h21;
      req_data[d][31:24] = 8'h43;
      req_valid[d] = 4'b1010;
      wait_cnt(d, 1'b0, gb + 1, 20);
      check("grant_after_rst", d, gl_idx[d][gb], 32'd1);
      wait_cnt(d, 1'b1, rb + 1, 40);
      check("rst_next_id", d, rl_id[d][rb], 32'd1);
      check("rst_next_data", d, 32'(rl_data[d][rb]), 32'h21 * coef_of(d));
      wait_cnt(d, 1'b1, rb + 2, 40);
      wait_idle();
    end

    // Pointer wrap: requester 3 alone, then requesters 0 and 3.
    for (int d = 0; d < 2; d++) begin
      gb = gl_n[d];
      req_valid[d] = 4'b1000;
      wait_cnt(d, 1'b0, gb + 1, 20);
      req_valid[d] = 4'b1001;
      wait_cnt(d, 1'b0, gb + 3, 60);
      check("wrap_g0", d, gl_idx[d][gb], 32'd3);
      check("wrap_g1", d, gl_idx[d][gb + 1], 32'd0);
      check("wrap_g2", d, gl_idx[d][gb + 2], 32'd3);
      wait_idle();
    end

    // Random traffic, random backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[d][i] && $urandom_range(0, 3) == 0) begin
            req_data[d][i*8 +: 8] = 8'($urandom);
            req_valid[d][i] = 1'b1;
          end
        end
        rsp_ready[d] = ($urandom_range(0, 9) < 7);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
